// File: rtl/jpeg_idct_pkg.sv
// Shared types and constants for the iDCT transpose-buffer read side.
// Used by jpeg_idctb_reader and jpeg_idctb_rdfifo.
package jpeg_idct_pkg;

    localparam int DW_DEF = 16;
    localparam logic [4:0] ADDR_LAST = 5'h1F;

    localparam int PAGE_W  = 3;
    localparam int COUNT_W = 2;
    localparam int LAST_W  = 1;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rdState_t;

    // FIFO entry = {page, count, last, laneA, laneB}
    function automatic int entryWidth(input int dw);
        return PAGE_W + COUNT_W + LAST_W + 2 * dw;
    endfunction

endpackage

// File: rtl/jpeg_idctb_rdfifo.sv
// First-word-fall-through register FIFO for the transpose-buffer reader.
// Push while full is accepted only together with a pop.
module jpeg_idctb_rdfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           popData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign doPop     = pop && !empty;
    assign doPush    = push && (!full || doPop);
    assign popData   = mem[rdPtr];

    // Pointer and occupancy bookkeeping; flush empties without touching data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= bump(wrPtr);
            if (doPop)  rdPtr <= bump(rdPtr);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    // Storage; cleared on reset so the outputs read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (doPush && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/jpeg_idctb_reader.sv
// Read-side sequencer for the iDCT transpose buffer: 32 reads per bank,
// lane swap fix-up, FWFT output. Optional: IDCTB_RD_BLKCNT_EN block counter.
module jpeg_idctb_reader
    import jpeg_idct_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          DataInit,
    input  logic          BufEnable,
    output logic          BufRead,
    output logic [4:0]    BufAddress,
    input  logic [DW-1:0] BufDataA,
    input  logic [DW-1:0] BufDataB,
    output logic          OutEnable,
    input  logic          OutReady,
    output logic [2:0]    OutPage,
    output logic [1:0]    OutCount,
    output logic [DW-1:0] OutDataA,
    output logic [DW-1:0] OutDataB,
    output logic          OutLast
`ifdef IDCTB_RD_BLKCNT_EN
    ,
    output logic [15:0]   OutBlockCount
`endif
);

    localparam int EW    = entryWidth(DW);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    rdState_t         state;
    rdState_t         stateNext;
    logic [4:0]       nextAddr;
    logic [4:0]       lastAddr;
    logic             inFlight;
    logic             credit;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [OCC_W-1:0] fifoOcc;
    logic             swap;
    logic [DW-1:0]    laneA;
    logic [DW-1:0]    laneB;
    logic             capture;
    logic [EW-1:0]    pushEntry;
    logic [EW-1:0]    popEntry;

    // A read may only be issued if its result is guaranteed a FIFO slot.
    assign credit = !fifoFull &&
                    ((int'(fifoOcc) + int'(inFlight)) < FIFO_DEPTH);

    // The buffer muxes its lanes with the live address, so a change of
    // address[4] since the read was issued leaves the lanes crossed.
    assign swap    = (BufAddress[4] != lastAddr[4]);
    assign laneA   = swap ? BufDataB : BufDataA;
    assign laneB   = swap ? BufDataA : BufDataB;
    assign capture = inFlight && !DataInit;

    assign pushEntry = {lastAddr[4:2], lastAddr[1:0],
                        (lastAddr == ADDR_LAST), laneA, laneB};

    assign BufAddress = BufRead ? nextAddr : lastAddr;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (DataInit) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: a bank is only left once address 0 is due again.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (BufEnable && credit) stateNext = READ;
            READ: if (nextAddr == '0 && !BufEnable) stateNext = IDLE;
        endcase
    end

    // Read strobe; mid-bank reads ignore BufEnable.
    always_comb begin
        BufRead = 1'b0;
        unique case (state)
            IDLE: BufRead = 1'b0;
            READ: BufRead = credit && (nextAddr != '0 || BufEnable);
        endcase
    end

    // Address counter and the one-deep in-flight tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nextAddr <= '0;
            lastAddr <= '0;
            inFlight <= 1'b0;
        end else if (DataInit) begin
            nextAddr <= '0;
            lastAddr <= '0;
            inFlight <= 1'b0;
        end else begin
            inFlight <= BufRead;
            if (BufRead) begin
                lastAddr <= nextAddr;
                nextAddr <= nextAddr + 5'd1;
            end
        end
    end

    jpeg_idctb_rdfifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (DataInit),
        .push      (capture),
        .pushData  (pushEntry),
        .pop       (OutReady),
        .popData   (popEntry),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .occupancy (fifoOcc)
    );

    assign OutEnable = !fifoEmpty;
    assign {OutPage, OutCount, OutLast, OutDataA, OutDataB} = popEntry;

`ifdef IDCTB_RD_BLKCNT_EN
    // Count blocks handed to stage 2; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OutBlockCount <= '0;
        end else if (DataInit) begin
            OutBlockCount <= '0;
        end else if (OutEnable && OutReady && OutLast) begin
            OutBlockCount <= OutBlockCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_idctb_reader.sv
// Scoreboard bench for jpeg_idctb_reader with a behavioural buffer model.
// Define IDCTB_RD_BLKCNT_EN to also check the block counter.
module tb_jpeg_idctb_reader;

    localparam int DW    = 16;
    localparam int DEPTH = 3;

    typedef struct {
        logic [2:0]  page;
        logic [1:0]  cnt;
        logic        last;
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DataInit = 1'b0;
    logic          BufEnable = 1'b0;
    logic          BufRead;
    logic [4:0]    BufAddress;
    logic [DW-1:0] BufDataA;
    logic [DW-1:0] BufDataB;
    logic          OutEnable;
    logic          OutReady = 1'b1;
    logic [2:0]    OutPage;
    logic [1:0]    OutCount;
    logic [DW-1:0] OutDataA;
    logic [DW-1:0] OutDataB;
    logic          OutLast;
`ifdef IDCTB_RD_BLKCNT_EN
    logic [15:0]   OutBlockCount;
`endif

    pair_t expQ[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int readCnt = 0;
    int xferCnt = 0;
    int lastCnt = 0;
    int lastReadCyc = 0;
    logic [4:0] expAddr = '0;

    jpeg_idctb_reader #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
`ifdef IDCTB_RD_BLKCNT_EN
        .OutBlockCount (OutBlockCount),
`endif
        .clk        (clk),
        .rst        (rst),
        .DataInit   (DataInit),
        .BufEnable  (BufEnable),
        .BufRead    (BufRead),
        .BufAddress (BufAddress),
        .BufDataA   (BufDataA),
        .BufDataB   (BufDataB),
        .OutEnable  (OutEnable),
        .OutReady   (OutReady),
        .OutPage    (OutPage),
        .OutCount   (OutCount),
        .OutDataA   (OutDataA),
        .OutDataB   (OutDataB),
        .OutLast    (OutLast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] valA(input logic [4:0] k);
        return {11'd0, k};
    endfunction
    function automatic logic [15:0] valB(input logic [4:0] k);
        return 16'h0100 + {11'd0, k};
    endfunction

    // Buffer model: lanes stored crossed for the upper half, output mux
    // driven by the live address, one cycle of read latency.
    logic [4:0]  rdK = '0;
    logic [15:0] lane0;
    logic [15:0] lane1;
    always @(posedge clk) if (BufRead) rdK <= BufAddress;
    assign lane0    = rdK[4] ? valB(rdK) : valA(rdK);
    assign lane1    = rdK[4] ? valA(rdK) : valB(rdK);
    assign BufDataA = BufAddress[4] ? lane1 : lane0;
    assign BufDataB = BufAddress[4] ? lane0 : lane1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBlock();
        logic [4:0] k;
        for (int i = 0; i < 32; i++) begin
            k = 5'(i);
            expQ.push_back('{k[4:2], k[1:0], (i == 31), valA(k), valB(k)});
        end
    endtask

    task automatic waitRead(input string name);
        int n = 0;
        while (!BufRead && n < 200) begin
            tick();
            n++;
        end
        if (!BufRead) chk(name, 0, 1);
    endtask

    task automatic wait31(input string name);
        int n = 0;
        while (!(BufRead && BufAddress == 5'd31) && n < 300) begin
            tick();
            n++;
        end
        chk(name, int'(BufRead && BufAddress == 5'd31), 1);
        tick();
    endtask

    task automatic waitXfer(input string name, input int target);
        int n = 0;
        while (xferCnt < target && n < 300) begin
            tick();
            n++;
        end
        chk(name, xferCnt, target);
    endtask

    // Monitor: address order, scoreboard pops, flush handling.
    initial begin
        pair_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                expAddr = '0;
            end else begin
                if (BufRead) begin
                    checks++;
                    if (BufAddress !== expAddr) begin
                        errors++;
                        $display("FAIL addr: got %0d expected %0d",
                                 BufAddress, expAddr);
                    end
                    expAddr = expAddr + 5'd1;
                    readCnt++;
                    lastReadCyc = cyc;
                end
                if (OutEnable && OutReady) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL pair: got unexpected page=%0d cnt=%0d expected none",
                                 OutPage, OutCount);
                    end else begin
                        e = expQ.pop_front();
                        if (OutPage !== e.page || OutCount !== e.cnt ||
                            OutLast !== e.last || OutDataA !== e.a ||
                            OutDataB !== e.b) begin
                            errors++;
                            $display("FAIL pair: got p%0d c%0d l%0d A=%h B=%h expected p%0d c%0d l%0d A=%h B=%h",
                                     OutPage, OutCount, OutLast, OutDataA, OutDataB,
                                     e.page, e.cnt, e.last, e.a, e.b);
                        end
                    end
                    xferCnt++;
                    if (OutLast) lastCnt++;
                end
                if (DataInit) begin
                    expQ.delete();
                    expAddr = '0;
                end
            end
        end
    end

    initial begin
        int t0;
        int r0;
        int x0;
        int l0;
        int n;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstBufRead", BufRead, 0);
        chk("rstBufAddress", BufAddress, 0);
        chk("rstOutEnable", OutEnable, 0);
        chk("rstOutLast", OutLast, 0);
        chk("rstOutPage", OutPage, 0);
        chk("rstOutCount", OutCount, 0);
        chk("rstOutDataA", OutDataA, 0);
        chk("rstOutDataB", OutDataB, 0);
`ifdef IDCTB_RD_BLKCNT_EN
        chk("rstBlkCnt", OutBlockCount, 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // Single bank, full rate, latency and swap boundaries.
        pushBlock();
        r0 = readCnt;
        x0 = xferCnt;
        l0 = lastCnt;
        BufEnable = 1'b1;
        waitRead("t1FirstRead");
        t0 = cyc;
        n = 0;
        while (!OutEnable && n < 10) begin
            tick();
            n++;
        end
        chk("t1Latency", cyc - t0, 2);
        wait31("t1Addr31");
        BufEnable = 1'b0;
        waitXfer("t1Xfers", x0 + 32);
        chk("t1Reads", readCnt - r0, 32);
        chk("t1ReadSpan", lastReadCyc - t0, 31);
        chk("t1Lasts", lastCnt - l0, 1);
        repeat (3) tick();
        chk("t1Idle", BufRead, 0);
        chk("t1QueueEmpty", expQ.size(), 0);

        // Backpressure from pair 5 for 10 cycles.
        pushBlock();
        r0 = readCnt;
        x0 = xferCnt;
        BufEnable = 1'b1;
        n = 0;
        while (!(OutEnable && OutPage == 3'd1 && OutCount == 2'd1) && n < 100) begin
            tick();
            n++;
        end
        OutReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3HoldEn", OutEnable, 1);
            chk("t3HoldA", OutDataA, 5);
            chk("t3HoldB", OutDataB, 'h105);
            tick();
        end
        chk("t3ReadStop", BufRead, 0);
        chk("t3Outstanding", (readCnt - r0) - (xferCnt - x0), DEPTH);
        OutReady = 1'b1;
        wait31("t3Addr31");
        BufEnable = 1'b0;
        waitXfer("t3Xfers", x0 + 32);

        // Two banks back to back.
        pushBlock();
        pushBlock();
        x0 = xferCnt;
        l0 = lastCnt;
        r0 = readCnt;
        BufEnable = 1'b1;
        wait31("t4Addr31a");
        chk("t4WrapRead", BufRead, 1);
        chk("t4WrapAddr", BufAddress, 0);
        wait31("t4Addr31b");
        BufEnable = 1'b0;
        waitXfer("t4Xfers", x0 + 64);
        chk("t4Reads", readCnt - r0, 64);
        chk("t4Lasts", lastCnt - l0, 2);
`ifdef IDCTB_RD_BLKCNT_EN
        chk("t4BlkCnt", OutBlockCount, 4);
`endif

        // DataInit while pair 12 is issued and pair 11 is in flight.
        pushBlock();
        x0 = xferCnt;
        BufEnable = 1'b1;
        n = 0;
        while (!(BufRead && BufAddress == 5'd12) && n < 100) begin
            tick();
            n++;
        end
        DataInit = 1'b1;
        BufEnable = 1'b0;
        tick();
        DataInit = 1'b0;
        chk("t5OutEnable", OutEnable, 0);
        chk("t5BufAddress", BufAddress, 0);
        chk("t5BufRead", BufRead, 0);
        chk("t5Xfers", xferCnt - x0, 11);
`ifdef IDCTB_RD_BLKCNT_EN
        chk("t5BlkCnt", OutBlockCount, 0);
`endif
        repeat (3) tick();
        chk("t5Idle", BufRead, 0);
        chk("t5IdleEn", OutEnable, 0);
        pushBlock();
        x0 = xferCnt;
        BufEnable = 1'b1;
        waitRead("t5Restart");
        chk("t5RestartAddr", BufAddress, 0);
        wait31("t5Addr31");
        BufEnable = 1'b0;
        waitXfer("t5Xfers2", x0 + 32);

        // One more full block, then reset in the middle of the next.
        pushBlock();
        x0 = xferCnt;
        BufEnable = 1'b1;
        wait31("t6Addr31");
        BufEnable = 1'b0;
        waitXfer("t6Xfers", x0 + 32);
`ifdef IDCTB_RD_BLKCNT_EN
        chk("t6BlkCnt", OutBlockCount, 2);
`endif
        pushBlock();
        x0 = xferCnt;
        BufEnable = 1'b1;
        waitXfer("t6Mid", x0 + 6);
        #2 rst = 1'b1;
        #1;
        chk("t6BufRead", BufRead, 0);
        chk("t6BufAddress", BufAddress, 0);
        chk("t6OutEnable", OutEnable, 0);
        chk("t6OutLast", OutLast, 0);
        chk("t6OutPage", OutPage, 0);
        chk("t6OutCount", OutCount, 0);
        chk("t6OutDataA", OutDataA, 0);
        chk("t6OutDataB", OutDataB, 0);
`ifdef IDCTB_RD_BLKCNT_EN
        chk("t6BlkCntRst", OutBlockCount, 0);
`endif
        BufEnable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t6PostIdle", BufRead, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
